// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Width of the wait and streak counters; both parameters top out at 15.
  localparam int CNT_W = 4;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Requester identifiers.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, DM and memory-macro signals around the arbiter.
// slave: the arbiter's view; master: the pipeline/memory side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
);

  // Instruction-fetch requester (read-only)
  logic                  if_req_87;
  logic [ADDR_WIDTH-1:0] if_addr_87;
  logic [DATA_WIDTH-1:0] if_rdata_87;
  logic                  if_ack_87;

  // Data-memory requester (read/write)
  logic                  dm_req_87;
  logic                  dm_we_87;
  logic [ADDR_WIDTH-1:0] dm_addr_87;
  logic [DATA_WIDTH-1:0] dm_wdata_87;
  logic [DATA_WIDTH-1:0] dm_rdata_87;
  logic                  dm_ack_87;

  // Memory macro
  logic                  mem_en_87;
  logic                  mem_we_87;
  logic [ADDR_WIDTH-1:0] mem_addr_87;
  logic [DATA_WIDTH-1:0] mem_wdata_87;
  logic [DATA_WIDTH-1:0] mem_rdata_87;

  // Hazard-unit status
  logic                  busy_87;

  modport slave (
    input  if_req_87, if_addr_87,
    output if_rdata_87, if_ack_87,
    input  dm_req_87, dm_we_87, dm_addr_87, dm_wdata_87,
    output dm_rdata_87, dm_ack_87,
    output mem_en_87, mem_we_87, mem_addr_87, mem_wdata_87,
    input  mem_rdata_87,
    output busy_87
  );

  modport master (
    output if_req_87, if_addr_87,
    input  if_rdata_87, if_ack_87,
    output dm_req_87, dm_we_87, dm_addr_87, dm_wdata_87,
    input  dm_rdata_87, dm_ack_87,
    input  mem_en_87, mem_we_87, mem_addr_87, mem_wdata_87,
    output mem_rdata_87,
    input  busy_87
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant selection between IF and DM: DM wins ties unless IF has been passed
// over STARVE_LIMIT times in a row, in which case IF is forced through.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_87,
  input  logic rst_87,
  input  logic if_req,
  input  logic dm_req,
  input  logic take,     // sequencer is idle and accepts a request this cycle
  output gnt_e grant
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_streak;
  logic             w_starved;

  assign w_starved = (r_streak == LIMIT);

  // Pick the requester; IF is the default when DM is silent or IF is starved.
  always_comb begin
    // NOTE: assign a default before any conditional so no path leaves the
    // output unassigned -- otherwise synthesis infers a latch.
    grant = GNT_IF;
    if (dm_req && !(if_req && w_starved)) grant = GNT_DM;
  end

  // Count consecutive DM grants taken while IF is kept waiting.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      r_streak <= '0;
    end else if (!if_req) begin
      r_streak <= '0;
    end else if (take) begin
      if (grant == GNT_IF)  r_streak <= '0;
      else if (!w_starved)  r_streak <= r_streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and DM accesses onto one fixed-latency single-ported memory:
// IDLE -> ISSUE (one strobe) -> WAIT (MEM_LAT cycles) -> RESP (one ack).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk_87,
  input  logic               rst_87,
  mem_port_arbiter_if.slave  bus
);

  state_e                r_state;
  state_e                w_next;
  gnt_e                  r_gnt;
  gnt_e                  w_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic [CNT_W-1:0]      r_cnt;

  logic w_any_req;
  logic w_take;
  logic w_mem_en;
  logic w_mem_we;
  logic w_if_ack;
  logic w_dm_ack;
  logic w_busy;

  assign w_any_req = bus.if_req_87 | bus.dm_req_87;
  assign w_take    = (r_state == ST_IDLE) & w_any_req;

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_pick (
    .clk_87 (clk_87),
    .rst_87 (rst_87),
    .if_req (bus.if_req_87),
    .dm_req (bus.dm_req_87),
    .take   (w_take),
    .grant  (w_grant)
  );

  // State register.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (rst_87) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_req)     w_next = ST_ISSUE;
      ST_ISSUE:                    w_next = ST_WAIT;
      ST_WAIT:  if (r_cnt == '0)   w_next = ST_RESP;
      ST_RESP:                     w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the current state only.
  always_comb begin
    w_mem_en = (r_state == ST_ISSUE);
    w_mem_we = (r_state == ST_ISSUE) & r_we;
    w_if_ack = (r_state == ST_RESP) & (r_gnt == GNT_IF);
    w_dm_ack = (r_state == ST_RESP) & (r_gnt == GNT_DM);
    w_busy   = (r_state != ST_IDLE);
  end

  // Latch the granted request, run the latency counter, capture read data.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      r_gnt      <= GNT_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt <= w_grant;
            if (w_grant == GNT_DM) begin
              r_addr  <= bus.dm_addr_87;
              r_we    <= bus.dm_we_87;
              r_wdata <= bus.dm_wdata_87;
            end else begin
              r_addr  <= bus.if_addr_87;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        ST_ISSUE: r_cnt <= CNT_W'(MEM_LAT - 1);
        ST_WAIT: begin
          if (r_cnt == '0) begin
            // Writes leave the requester's read-data register untouched.
            if (!r_we) begin
              if (r_gnt == GNT_DM) r_dm_rdata <= bus.mem_rdata_87;
              else                 r_if_rdata <= bus.mem_rdata_87;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en_87    = w_mem_en;
  assign bus.mem_we_87    = w_mem_we;
  assign bus.mem_addr_87  = r_addr;
  assign bus.mem_wdata_87 = r_wdata;
  assign bus.if_ack_87    = w_if_ack;
  assign bus.dm_ack_87    = w_dm_ack;
  assign bus.if_rdata_87  = r_if_rdata;
  assign bus.dm_rdata_87  = r_dm_rdata;
  assign bus.busy_87      = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected acks/strobes, monitors pop them.
// dut2 runs with MEM_LAT=2, dut1 with MEM_LAT=1; each has a latency memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk_87 = 1'b0;
  logic rst_87 = 1'b1;
  int   cyc    = 0;

  always #5 clk_87 = ~clk_87;
  always @(posedge clk_87) cyc <= cyc + 1;

  mem_port_arbiter_if bus2 ();
  mem_port_arbiter_if bus1 ();

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) dut2 (
    .clk_87 (clk_87), .rst_87 (rst_87), .bus (bus2));
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) dut1 (
    .clk_87 (clk_87), .rst_87 (rst_87), .bus (bus1));

  typedef struct { bit is_dm; logic [31:0] data; int cyc; } ack_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } acc_t;

  ack_t ack2_q[$];
  ack_t ack1_q[$];
  acc_t acc2_q[$];
  ack_t m2_ack, m1_ack;
  acc_t m2_acc;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- memory models ----------------
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] d2_0 = '0, d2_1 = '0, d1_0 = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return {~a[15:0], a[15:0]};
  endfunction

  always @(posedge clk_87) begin
    if (bus2.mem_en_87 && bus2.mem_we_87) wmem[bus2.mem_addr_87] = bus2.mem_wdata_87;
    d2_0 <= !bus2.mem_en_87 ? 32'h0 :
            (bus2.mem_we_87 ? 32'hBADC0FFE : mem_rd(bus2.mem_addr_87));
    d2_1 <= d2_0;
    d1_0 <= bus1.mem_en_87 ? mem_rd(bus1.mem_addr_87) : 32'h0;
  end
  assign bus2.mem_rdata_87 = d2_1;
  assign bus1.mem_rdata_87 = d1_0;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // dut2 monitor: acks and memory strobes against their queues.
  always @(negedge clk_87) begin
    if (bus2.if_ack_87 || bus2.dm_ack_87) begin
      check("ack2_exclusive", {31'b0, bus2.if_ack_87 & bus2.dm_ack_87}, 32'h0);
      if (ack2_q.size() == 0) begin
        check("ack2_unexpected", ack2_q.size(), 1);
      end else begin
        m2_ack = ack2_q.pop_front();
        check("ack2_requester", {31'b0, bus2.dm_ack_87}, {31'b0, m2_ack.is_dm});
        check("ack2_rdata", m2_ack.is_dm ? bus2.dm_rdata_87 : bus2.if_rdata_87, m2_ack.data);
        if (m2_ack.cyc >= 0) check("ack2_cycle", cyc, m2_ack.cyc);
      end
    end
    if (bus2.mem_en_87) begin
      if (acc2_q.size() == 0) begin
        check("mem2_unexpected_strobe", acc2_q.size(), 1);
      end else begin
        m2_acc = acc2_q.pop_front();
        check("mem2_addr", bus2.mem_addr_87, m2_acc.addr);
        check("mem2_we", {31'b0, bus2.mem_we_87}, {31'b0, m2_acc.we});
        if (m2_acc.we) check("mem2_wdata", bus2.mem_wdata_87, m2_acc.wdata);
        if (m2_acc.cyc >= 0) check("mem2_cycle", cyc, m2_acc.cyc);
      end
    end
  end

  // dut1 monitor: acks only.
  always @(negedge clk_87) begin
    if (bus1.if_ack_87 || bus1.dm_ack_87) begin
      if (ack1_q.size() == 0) begin
        check("ack1_unexpected", ack1_q.size(), 1);
      end else begin
        m1_ack = ack1_q.pop_front();
        check("ack1_requester", {31'b0, bus1.dm_ack_87}, {31'b0, m1_ack.is_dm});
        check("ack1_rdata", bus1.if_rdata_87, m1_ack.data);
        check("ack1_cycle", cyc, m1_ack.cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic align();
    @(posedge clk_87);
    #1;
  endtask

  // Push expected ack and strobe for dut2; timing is checked when the request
  // is raised into an idle arbiter (ack MEM_LAT+2 = 4 cycles later).
  task automatic exp2(input bit is_dm, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] data, input bit from_idle);
    ack_t k;
    acc_t m;
    k.is_dm = is_dm; k.data = data; k.cyc = from_idle ? cyc + 4 : -1;
    m.we = we; m.addr = a; m.wdata = wd; m.cyc = from_idle ? cyc + 1 : -1;
    ack2_q.push_back(k);
    acc2_q.push_back(m);
  endtask

  task automatic wait_ack2(input bit is_dm);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk_87);
      seen = is_dm ? bus2.dm_ack_87 : bus2.if_ack_87;
    end
    if (!seen) check("ack2_timeout", {31'b0, seen}, 32'd1);
    align();
  endtask

  task automatic if2(input logic [31:0] a);
    bus2.if_req_87 = 1'b1; bus2.if_addr_87 = a;
    wait_ack2(1'b0);
    bus2.if_req_87 = 1'b0;
  endtask

  task automatic dm2(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus2.dm_req_87 = 1'b1; bus2.dm_we_87 = we; bus2.dm_addr_87 = a; bus2.dm_wdata_87 = wd;
    wait_ack2(1'b1);
    bus2.dm_req_87 = 1'b0;
  endtask

  task automatic if1(input logic [31:0] a);
    bit seen = 1'b0;
    bus1.if_req_87 = 1'b1; bus1.if_addr_87 = a;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk_87);
      seen = bus1.if_ack_87;
    end
    if (!seen) check("ack1_timeout", {31'b0, seen}, 32'd1);
    align();
    bus1.if_req_87 = 1'b0;
  endtask

  task automatic check_zero2(input string tag);
    check({tag, "_busy"},      {31'b0, bus2.busy_87},   32'h0);
    check({tag, "_if_ack"},    {31'b0, bus2.if_ack_87}, 32'h0);
    check({tag, "_dm_ack"},    {31'b0, bus2.dm_ack_87}, 32'h0);
    check({tag, "_mem_en"},    {31'b0, bus2.mem_en_87}, 32'h0);
    check({tag, "_mem_we"},    {31'b0, bus2.mem_we_87}, 32'h0);
    check({tag, "_mem_addr"},  bus2.mem_addr_87,        32'h0);
    check({tag, "_mem_wdata"}, bus2.mem_wdata_87,       32'h0);
    check({tag, "_if_rdata"},  bus2.if_rdata_87,        32'h0);
    check({tag, "_dm_rdata"},  bus2.dm_rdata_87,        32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] last_dm;
    logic [31:0] a;
    int c;

    bus2.if_req_87 = 1'b0; bus2.if_addr_87 = '0;
    bus2.dm_req_87 = 1'b0; bus2.dm_we_87 = 1'b0; bus2.dm_addr_87 = '0; bus2.dm_wdata_87 = '0;
    bus1.if_req_87 = 1'b0; bus1.if_addr_87 = '0;
    bus1.dm_req_87 = 1'b0; bus1.dm_we_87 = 1'b0; bus1.dm_addr_87 = '0; bus1.dm_wdata_87 = '0;
    wmem[32'h40] = 32'hDEADBEEF;

    // Reset state
    rst_87 = 1'b1;
    align(); align();
    check_zero2("reset");
    #2 rst_87 = 1'b0;
    align();

    // Single IF read from idle: strobe at +1, ack at +4, busy on cycles +1..+4
    c = cyc;
    exp2(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1);
    fork
      if2(32'h40);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk_87);
        check($sformatf("busy_c%0d", k), {31'b0, bus2.busy_87},
              (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      end
    join
    align();

    // DM read, write, read-back; the write ack must leave dm_rdata alone
    last_dm = 32'hFCFF0300;  // {~16'h0300, 16'h0300}
    exp2(1'b1, 1'b0, 32'h300, 32'h0, last_dm, 1'b1);
    dm2(1'b0, 32'h300, 32'h0);
    exp2(1'b1, 1'b1, 32'h80, 32'h12345678, last_dm, 1'b1);
    dm2(1'b1, 32'h80, 32'h12345678);
    exp2(1'b1, 1'b0, 32'h80, 32'h0, 32'h12345678, 1'b1);
    dm2(1'b0, 32'h80, 32'h0);

    // Continuous contention: DM x4, IF, DM x4, IF
    for (int k = 0; k < 4; k++) exp2(1'b1, 1'b0, 32'h200 + 4 * k, 32'h0, mem_rd(32'h200 + 4 * k), 1'b0);
    exp2(1'b0, 1'b0, 32'h100, 32'h0, 32'hFEFF0100, 1'b0);
    for (int k = 4; k < 8; k++) exp2(1'b1, 1'b0, 32'h200 + 4 * k, 32'h0, mem_rd(32'h200 + 4 * k), 1'b0);
    exp2(1'b0, 1'b0, 32'h104, 32'h0, 32'hFEFB0104, 1'b0);
    fork
      begin if2(32'h100); if2(32'h104); end
      begin for (int k = 0; k < 8; k++) dm2(1'b0, 32'h200 + 4 * k, 32'h0); end
    join

    // DM raised during an IF access and withdrawn before it could be granted
    exp2(1'b0, 1'b0, 32'h600, 32'h0, 32'hF9FF0600, 1'b1);
    fork
      begin
        if2(32'h600);
        exp2(1'b0, 1'b0, 32'h604, 32'h0, 32'hF9FB0604, 1'b1);
        if2(32'h604);
      end
      begin
        align();
        bus2.dm_req_87 = 1'b1; bus2.dm_we_87 = 1'b0; bus2.dm_addr_87 = 32'h700;
        align(); align();
        bus2.dm_req_87 = 1'b0;
      end
    join

    // Async reset during WAIT of a DM read: outputs clear at once, no ack later
    begin
      acc_t m;
      m.we = 1'b0; m.addr = 32'h500; m.wdata = 32'h0; m.cyc = cyc + 1;
      acc2_q.push_back(m);
    end
    bus2.dm_req_87 = 1'b1; bus2.dm_we_87 = 1'b0; bus2.dm_addr_87 = 32'h500;
    align(); align();
    #1 rst_87 = 1'b1;
    #1 check_zero2("rst_mid");
    bus2.dm_req_87 = 1'b0;
    align(); align();
    #1 rst_87 = 1'b0;
    repeat (8) align();
    exp2(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1);
    if2(32'h40);

    // MEM_LAT=1: back-to-back IF reads, one ack every 4 cycles
    for (int k = 0; k < 100; k++) begin
      ack_t e;
      a = $urandom & 32'h0000_FFFC;
      e.is_dm = 1'b0; e.data = mem_rd(a); e.cyc = cyc + 3;
      ack1_q.push_back(e);
      if1(a);
    end

    repeat (5) align();
    check("ack2_q_drained", ack2_q.size(), 0);
    check("acc2_q_drained", acc2_q.size(), 0);
    check("ack1_q_drained", ack1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
